// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ARM data-processing ALU:
// opcode encodings, FSM states and NZCV flag bit positions.
package alu_pkg;

  localparam logic [4:0] OP_AND = 5'd0;
  localparam logic [4:0] OP_EOR = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_RSB = 5'd3;
  localparam logic [4:0] OP_ADD = 5'd4;
  localparam logic [4:0] OP_ADC = 5'd5;
  localparam logic [4:0] OP_SBC = 5'd6;
  localparam logic [4:0] OP_RSC = 5'd7;
  localparam logic [4:0] OP_TST = 5'd8;
  localparam logic [4:0] OP_TEQ = 5'd9;
  localparam logic [4:0] OP_CMP = 5'd10;
  localparam logic [4:0] OP_CMN = 5'd11;
  localparam logic [4:0] OP_ORR = 5'd12;
  localparam logic [4:0] OP_MOV = 5'd13;
  localparam logic [4:0] OP_BIC = 5'd14;
  localparam logic [4:0] OP_MVN = 5'd15;
  localparam logic [4:0] OP_MUL = 5'd16;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Opcodes that go through the adder and therefore produce a real V.
  function automatic logic is_arith(input logic [4:0] op);
    return op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN};
  endfunction

endpackage

// File: rtl/alu_dp_core.sv
// Combinational core for the 16 ARM data-processing opcodes.
// Arithmetic is done at WIDTH+1 bits so the top bit is the ARM carry (NOT borrow for subtracts).
module alu_dp_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  input  logic             i_cin,
  input  logic             i_shift_c,
  output logic [WIDTH-1:0] o_result,
  output logic             o_n,
  output logic             o_z,
  output logic             o_c,
  output logic             o_v,
  output logic             o_wr,
  output logic             o_is_cmp
);

  logic [4:0]       w_op;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_logic;
  logic             w_ci;
  logic             w_arith;
  logic [WIDTH:0]   w_sum;

  assign w_op = {1'b0, i_op};

  // Every arithmetic op is x + y + ci with the operands swapped/inverted as needed.
  always_comb begin
    w_x  = i_a;
    w_y  = i_b;
    w_ci = 1'b0;
    case (w_op)
      OP_ADC:         w_ci = i_cin;
      OP_SUB, OP_CMP: begin w_y = ~i_b; w_ci = 1'b1;  end
      OP_SBC:         begin w_y = ~i_b; w_ci = i_cin; end
      OP_RSB:         begin w_x = i_b;  w_y = ~i_a; w_ci = 1'b1;  end
      OP_RSC:         begin w_x = i_b;  w_y = ~i_a; w_ci = i_cin; end
      default: ;
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_ci};

  always_comb begin
    w_logic = '0;
    case (w_op)
      OP_AND, OP_TST: w_logic = i_a & i_b;
      OP_EOR, OP_TEQ: w_logic = i_a ^ i_b;
      OP_ORR:         w_logic = i_a | i_b;
      OP_MOV:         w_logic = i_b;
      OP_BIC:         w_logic = i_a & ~i_b;
      OP_MVN:         w_logic = ~i_b;
      default: ;
    endcase
  end

  assign w_arith  = is_arith(w_op);
  assign o_result = w_arith ? w_sum[WIDTH-1:0] : w_logic;
  assign o_n      = o_result[WIDTH-1];
  assign o_z      = (o_result == '0);
  assign o_c      = w_arith ? w_sum[WIDTH] : i_shift_c;
  assign o_v      = w_arith & (w_x[WIDTH-1] == w_y[WIDTH-1]) & (w_sum[WIDTH-1] != w_x[WIDTH-1]);
  assign o_is_cmp = w_op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
  assign o_wr     = ~o_is_cmp;

endmodule

// File: rtl/alu_seq.sv
// Registered ARM data-processing ALU with NZCV flag register and an iterative shift-add MUL.
// Valid/ready on both sides; single-cycle DP ops sustain one result per cycle.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_flags,
  input  logic             shift_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_wr,
  output logic             out_err,
  input  logic             flags_wr,
  input  logic [3:0]       flags_in,
  output logic [3:0]       flags
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_valid;
  logic             r_wr;
  logic             r_err;
  logic             r_sf;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_flags;
  logic [3:0]       w_flags_nxt;

  logic             w_accept;
  logic             w_is_dp;
  logic             w_is_mul;
  logic             w_load_dp;
  logic             w_load_mul;

  logic [WIDTH-1:0] w_dp_result;
  logic             w_dp_n;
  logic             w_dp_z;
  logic             w_dp_c;
  logic             w_dp_v;
  logic             w_dp_wr;
  logic             w_dp_is_cmp;

  alu_dp_core #(
    .WIDTH(WIDTH)
  ) u_dp_core (
    .i_a      (a),
    .i_b      (b),
    .i_op     (op[3:0]),
    .i_cin    (r_flags[FLAG_C]),
    .i_shift_c(shift_c),
    .o_result (w_dp_result),
    .o_n      (w_dp_n),
    .o_z      (w_dp_z),
    .o_c      (w_dp_c),
    .o_v      (w_dp_v),
    .o_wr     (w_dp_wr),
    .o_is_cmp (w_dp_is_cmp)
  );

  assign in_ready   = (r_state == IDLE) && (!r_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_is_dp    = ~op[4];
  assign w_is_mul   = MUL_EN && (op == OP_MUL);
  // Illegal opcodes also take the single-cycle path, reporting out_err.
  assign w_load_dp  = w_accept && !w_is_mul;
  assign w_load_mul = (r_state == DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_is_mul) w_state_nxt = MUL;
      MUL:     if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_flags_nxt = r_flags;
    if (w_load_mul) begin
      if (r_sf) begin
        w_flags_nxt[FLAG_N] = r_acc[WIDTH-1];
        w_flags_nxt[FLAG_Z] = (r_acc == '0);
      end
    end else if (w_load_dp && w_is_dp && (w_dp_is_cmp || set_flags)) begin
      w_flags_nxt[FLAG_N] = w_dp_n;
      w_flags_nxt[FLAG_Z] = w_dp_z;
      w_flags_nxt[FLAG_C] = w_dp_c;
      if (is_arith(op)) w_flags_nxt[FLAG_V] = w_dp_v;
    end
    if (flags_wr) w_flags_nxt = flags_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_flags  <= 4'b0000;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_wr     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_flags <= w_flags_nxt;
      if (w_load_dp) begin
        r_valid  <= 1'b1;
        r_result <= w_is_dp ? w_dp_result : '0;
        r_wr     <= w_is_dp && w_dp_wr;
        r_err    <= ~w_is_dp;
      end else if (w_load_mul) begin
        r_valid  <= 1'b1;
        r_result <= r_acc;
        r_wr     <= 1'b1;
        r_err    <= 1'b0;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  // One multiplier bit per cycle, LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sf     <= 1'b0;
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sf     <= set_flags;
    end else if (r_state == MUL) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  assign out_valid = r_valid;
  assign result    = r_result;
  assign out_wr    = r_wr;
  assign out_err   = r_err;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed literal checks plus randomized traffic
// compared every cycle against a signed/unsigned-arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        op = '0;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              set_flags = 1'b0;
  logic              shift_c = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  result;
  logic              out_wr;
  logic              out_err;
  logic              flags_wr = 1'b0;
  logic [3:0]        flags_in = '0;
  logic [3:0]        flags;

  alu_seq #(
    .WIDTH (WIDTH),
    .MUL_EN(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .set_flags(set_flags),
    .shift_c  (shift_c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .out_wr   (out_wr),
    .out_err  (out_err),
    .flags_wr (flags_wr),
    .flags_in (flags_in),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_valid = 1'b0;
  logic        m_wr = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_res = '0;
  logic [3:0]  m_flags = '0;
  int          m_mul_left = 0;
  logic [31:0] m_mul_res = '0;
  logic        m_mul_sf = 1'b0;
  logic        m_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags from the architectural definitions: V from true signed range, C from unsigned compare.
  task automatic dp_ref(input logic [4:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input logic ci, input logic sc, output logic [31:0] r,
                        output logic c, output logic v, output logic arith);
    longint sa, sb, ua, ub, cl, ss;
    longint two32;
    two32 = 64'sh1_0000_0000;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    ua = longint'({32'b0, xa});
    ub = longint'({32'b0, xb});
    cl = longint'({63'b0, ci});
    arith = 1'b1;
    c = 1'b0;
    v = 1'b0;
    ss = 0;
    r = '0;
    case (o)
      OP_ADD, OP_CMN: begin ss = sa + sb;      c = (ua + ub) >= two32;      end
      OP_ADC:         begin ss = sa + sb + cl; c = (ua + ub + cl) >= two32; end
      OP_SUB, OP_CMP: begin ss = sa - sb;      c = ua >= ub;                end
      OP_SBC: begin ss = sa - sb - 64'sd1 + cl; c = ua >= (ub + 64'sd1 - cl); end
      OP_RSB:         begin ss = sb - sa;      c = ub >= ua;                end
      OP_RSC: begin ss = sb - sa - 64'sd1 + cl; c = ub >= (ua + 64'sd1 - cl); end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      r = ss[31:0];
      v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    end else begin
      c = sc;
      case (o)
        OP_AND, OP_TST: r = xa & xb;
        OP_EOR, OP_TEQ: r = xa ^ xb;
        OP_ORR:         r = xa | xb;
        OP_MOV:         r = xb;
        OP_BIC:         r = xa & ~xb;
        OP_MVN:         r = ~xb;
        default:        r = '0;
      endcase
    end
  endtask

  task automatic model_edge();
    logic        fire;
    logic [31:0] r;
    logic        c, v, ar;
    fire = in_valid && m_ready;
    if (m_valid && out_ready) m_valid = 1'b0;
    if (m_mul_left > 0) begin
      m_mul_left--;
      if (m_mul_left == 0) begin
        m_valid = 1'b1;
        m_res = m_mul_res;
        m_wr = 1'b1;
        m_err = 1'b0;
        if (m_mul_sf) begin
          m_flags[3] = m_res[31];
          m_flags[2] = (m_res == 0);
        end
      end
    end else if (fire) begin
      if (op < 5'd16) begin
        dp_ref(op, a, b, m_flags[1], shift_c, r, c, v, ar);
        m_valid = 1'b1;
        m_res = r;
        m_err = 1'b0;
        m_wr = !(op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
        if (!m_wr || set_flags) begin
          m_flags[3] = r[31];
          m_flags[2] = (r == 0);
          m_flags[1] = c;
          if (ar) m_flags[0] = v;
        end
      end else if (op == OP_MUL) begin
        m_mul_left = int'(WIDTH) + 1;
        m_mul_res = a * b;
        m_mul_sf = set_flags;
      end else begin
        m_valid = 1'b1;
        m_wr = 1'b0;
        m_err = 1'b1;
      end
    end
    if (flags_wr) m_flags = flags_in;
  endtask

  task automatic compare_regs();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("flags", 32'(flags), 32'(m_flags));
    if (m_valid) begin
      chk("out_wr", 32'(out_wr), 32'(m_wr));
      chk("out_err", 32'(out_err), 32'(m_err));
      if (!m_err) chk("result", result, m_res);
    end
  endtask

  // Called at posedge+1; drives one cycle, checks in_ready, then registered outputs.
  task automatic cycle(input logic v, input logic [4:0] o, input logic [31:0] xa,
                       input logic [31:0] xb, input logic s, input logic sc, input logic ordy,
                       input logic fw, input logic [3:0] fi, output logic acc);
    in_valid = v;
    op = o;
    a = xa;
    b = xb;
    set_flags = s;
    shift_c = sc;
    out_ready = ordy;
    flags_wr = fw;
    flags_in = fi;
    m_ready = (m_mul_left == 0) && (!m_valid || ordy);
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    acc = v && m_ready;
    @(posedge clk);
    model_edge();
    #1;
    compare_regs();
  endtask

  task automatic go(input logic [4:0] o, input logic [31:0] xa, input logic [31:0] xb,
                    input logic s, output logic acc);
    cycle(1'b1, o, xa, xb, s, 1'b0, 1'b1, 1'b0, 4'h0, acc);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flags_wr = 1'b0;
    #1;
    m_valid = 1'b0;
    m_flags = '0;
    m_mul_left = 0;
    m_res = '0;
    m_wr = 1'b0;
    m_err = 1'b0;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst flags", 32'(flags), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst out_wr", 32'(out_wr), 32'd0);
    chk("rst out_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
  endtask

  logic [31:0] edge_vals[5] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1};

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic        acc;
    int          rej;
    logic        pv, ps, psc, pend;
    logic [4:0]  po;
    logic [31:0] pa, pb;
    int          sel;

    #1;
    apply_reset();

    go(OP_SUB, 32'h0, 32'h2, 1'b1, acc);
    chk("sub result", result, 32'hFFFF_FFFE);
    chk("sub out_wr", 32'(out_wr), 32'd1);
    chk("sub nzcv", 32'(flags), 32'b1000);

    go(OP_ADD, 32'h4000_0000, 32'h4000_0000, 1'b1, acc);
    chk("add ovf result", result, 32'h8000_0000);
    chk("add ovf nzcv", 32'(flags), 32'b1001);

    go(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1, acc);
    chk("add carry result", result, 32'h0);
    chk("add carry nzcv", 32'(flags), 32'b0110);

    go(OP_ADC, 32'hFFFF_FFFF, 32'h1, 1'b1, acc);
    chk("adc result", result, 32'h1);
    chk("adc nzcv", 32'(flags), 32'b0010);

    go(OP_CMP, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, acc);
    chk("cmp out_wr", 32'(out_wr), 32'd0);
    chk("cmp nzcv", 32'(flags), 32'b0110);

    go(5'd20, 32'h1234, 32'h5678, 1'b1, acc);
    chk("illegal out_err", 32'(out_err), 32'd1);
    chk("illegal out_wr", 32'(out_wr), 32'd0);
    chk("illegal nzcv", 32'(flags), 32'b0110);

    go(OP_MUL, 32'd7, 32'd6, 1'b1, acc);
    chk("mul accepted", 32'(acc), 32'd1);
    rej = 0;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      cycle(1'b1, OP_ADD, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, acc);
      if (!acc) begin
        rej++;
        if (rej == 33) begin
          chk("mul result", result, 32'd42);
          chk("mul out_wr", 32'(out_wr), 32'd1);
        end
      end
    end
    chk("mul busy cycles", 32'(rej), 32'd33);
    chk("held op result", result, 32'd3);

    go(OP_ADD, 32'd5, 32'd6, 1'b0, acc);
    chk("stall first", result, 32'd11);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, OP_ADD, 32'd7, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, acc);
      chk("stall no accept", 32'(acc), 32'd0);
      chk("stall held", result, 32'd11);
    end
    go(OP_ADD, 32'd7, 32'd8, 1'b0, acc);
    chk("stall release accept", 32'(acc), 32'd1);
    chk("stall release result", result, 32'd15);

    cycle(1'b1, OP_ADD, 32'd1, 32'd1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0101, acc);
    chk("flags_wr wins", 32'(flags), 32'b0101);

    pend = 1'b0;
    pv = 1'b0; ps = 1'b0; psc = 1'b0; po = '0; pa = '0; pb = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend) begin
        pv = ($urandom_range(0, 3) != 0);
        sel = int'($urandom_range(0, 99));
        if (sel < 93)      po = 5'($urandom_range(0, 15));
        else if (sel < 96) po = OP_MUL;
        else               po = 5'($urandom_range(17, 31));
        pa = pick_operand();
        pb = pick_operand();
        ps = 1'($urandom_range(0, 1));
        psc = 1'($urandom_range(0, 1));
      end
      cycle(pv, po, pa, pb, ps, psc, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)), acc);
      pend = pv && !acc;
    end

    cycle(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, acc);
    go(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, acc);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, acc);
    end
    apply_reset();
    go(OP_ADD, 32'd2, 32'd3, 1'b1, acc);
    chk("post reset add", result, 32'd5);
    chk("post reset nzcv", 32'(flags), 32'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
